// File: rtl/hamming_link_bist.sv
// Hamming link self-test: LFSR generator -> encoder -> error injector/decoder -> checker.
// Define HAMMING_SECDED_EN for SECDED (overall parity at position 0); default build is SEC only.
module hamming_link_bist #(
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       P_W    = 5,
    parameter int unsigned       CNT_W  = 16,
    parameter logic [DATA_W-1:0] SEED   = 16'hACE1,
    parameter logic [DATA_W-1:0] TAPS   = 16'hB400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [1:0]        inj_mode,
    input  logic [7:0]        inj_pos,
    input  logic [7:0]        inj_pos2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out_all,
    output logic [CNT_W-1:0]  err_corr_cnt,
    output logic [CNT_W-1:0]  err_uncorr_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  words_cnt
);

    localparam int unsigned N = DATA_W + P_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Codeword position of data bit idx: non-power-of-two positions, ascending.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned k;
        int unsigned p;
        k = 0;
        p = 0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (k == idx) p = pos;
                k++;
            end
        end
        return p;
    endfunction

    function automatic logic [N:0] encode(input logic [DATA_W-1:0] d);
        logic [N:0] cw;
        logic       par;
        cw = '0;
        for (int unsigned j = 0; j < DATA_W; j++) cw[data_pos(j)] = d[j];
        for (int unsigned i = 0; i < P_W; i++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos <= N; pos++) begin
                if (((pos >> i) & 1) != 0) par = par ^ cw[pos];
            end
            if ((1 << i) <= N) cw[1 << i] = par;
        end
`ifdef HAMMING_SECDED_EN
        cw[0] = ^cw[N:1];
`endif
        return cw;
    endfunction

    function automatic logic [P_W-1:0] syndrome(input logic [N:0] cw);
        logic [P_W-1:0] s;
        s = '0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if (cw[pos]) s = s ^ P_W'(pos);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [N:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned j = 0; j < DATA_W; j++) d[j] = cw[data_pos(j)];
        return d;
    endfunction

    function automatic logic pos_ok(input logic [7:0] p);
`ifdef HAMMING_SECDED_EN
        return 32'(p) <= N;
`else
        return (p != 8'd0) && (32'(p) <= N);
`endif
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         pos1_q, pos1_d, pos2_q, pos2_d;
    logic [DATA_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [1:0]         drain_cnt_q, drain_cnt_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               s1_valid_q, s1_valid_d;
    logic [N:0]         s1_cw_q, s1_cw_d;
    logic [DATA_W-1:0]  s1_ref_q, s1_ref_d;
    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d, s2_ref_q, s2_ref_d;
    logic               s2_corr_q, s2_corr_d, s2_uncorr_q, s2_uncorr_d;

    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [CNT_W-1:0]   words_q, words_d, corr_q, corr_d, uncorr_q, uncorr_d, mism_q, mism_d;

    logic               start_acc, issue;
    logic               flip1_en, flip2_en;
    logic [N:0]         inj_cw, dec_cw;
    logic [P_W-1:0]     syn;

    // Control FSM
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        issue       = 1'b0;
        num_d       = num_q;
        mode_d      = mode_q;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;
        issue_cnt_d = issue_cnt_q;
        drain_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    num_d       = num_words;
                    mode_d      = inj_mode;
                    pos1_d      = inj_pos;
                    pos2_d      = inj_pos2;
                    issue_cnt_d = '0;
                    state_d     = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue       = 1'b1;
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q == num_q - 1'b1) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == 2'd2) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // done is registered off the DONE state, so busy drops on the same edge.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);

        lfsr_d = lfsr_q;
        if (start_acc) begin
            lfsr_d = SEED;
        end else if (issue) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    // Datapath: encode (S1), inject + decode (S2), compare + count (S3)
    always_comb begin
        s1_valid_d = issue;
        s1_cw_d    = encode(lfsr_q);
        s1_ref_d   = lfsr_q;

        flip1_en = ((mode_q == 2'b01) || (mode_q == 2'b10)) && pos_ok(pos1_q);
        flip2_en = (mode_q == 2'b10) && pos_ok(pos2_q);
        inj_cw   = s1_cw_q;
        for (int unsigned pos = 0; pos <= N; pos++) begin
            if (flip1_en && (pos == 32'(pos1_q))) inj_cw[pos] = ~inj_cw[pos];
            if (flip2_en && (pos == 32'(pos2_q))) inj_cw[pos] = ~inj_cw[pos];
        end

        syn         = syndrome(inj_cw);
        dec_cw      = inj_cw;
        s2_corr_d   = 1'b0;
        s2_uncorr_d = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (^inj_cw) begin
            if (syn == '0) begin
                s2_corr_d = 1'b1;
            end else if (32'(syn) <= N) begin
                dec_cw[syn] = ~dec_cw[syn];
                s2_corr_d   = 1'b1;
            end else begin
                s2_uncorr_d = 1'b1;
            end
        end else if (syn != '0) begin
            s2_uncorr_d = 1'b1;
        end
`else
        if (syn != '0) begin
            if (32'(syn) <= N) begin
                dec_cw[syn] = ~dec_cw[syn];
                s2_corr_d   = 1'b1;
            end else begin
                s2_uncorr_d = 1'b1;
            end
        end
`endif
        s2_valid_d = s1_valid_q;
        s2_data_d  = extract(dec_cw);
        s2_ref_d   = s1_ref_q;

        data_out_d = data_out_q;
        words_d    = words_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        mism_d     = mism_q;
        if (start_acc) begin
            words_d  = '0;
            corr_d   = '0;
            uncorr_d = '0;
            mism_d   = '0;
        end else if (s2_valid_q) begin
            data_out_d = s2_data_q;
            words_d    = sat_inc(words_q, 1'b1);
            corr_d     = sat_inc(corr_q, s2_corr_q);
            uncorr_d   = sat_inc(uncorr_q, s2_uncorr_q);
            mism_d     = sat_inc(mism_q, s2_data_q != s2_ref_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            mode_q      <= '0;
            pos1_q      <= '0;
            pos2_q      <= '0;
            lfsr_q      <= SEED;
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_ref_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_ref_q    <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
            data_out_q  <= '0;
            words_q     <= '0;
            corr_q      <= '0;
            uncorr_q    <= '0;
            mism_q      <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            mode_q      <= mode_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
            lfsr_q      <= lfsr_d;
            issue_cnt_q <= issue_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_ref_q    <= s1_ref_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_ref_q    <= s2_ref_d;
            s2_corr_q   <= s2_corr_d;
            s2_uncorr_q <= s2_uncorr_d;
            data_out_q  <= data_out_d;
            words_q     <= words_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
            mism_q      <= mism_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign data_out_all   = data_out_q;
    assign err_corr_cnt   = corr_q;
    assign err_uncorr_cnt = uncorr_q;
    assign mismatch_cnt   = mism_q;
    assign words_cnt      = words_q;

endmodule
